// File: rtl/uc_pkg.sv
// Shared constants and types for the multi-cycle MIPS32 control unit:
// opcodes, state encoding, datapath mux codes and the control word.
package uc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // The 4-bit encoding leaves 11..15 unused; those fall back to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control bus between the multi-cycle controller and the shared datapath.
// master = controller side, slave = datapath side.
interface uc_multiciclo_if;

    logic [5:0] OpCode;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       IRWrite;
    logic       MemToRead;
    logic       MemToWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] AluOp;
    logic [1:0] PCSrc;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  OpCode, Zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemToRead, MemToWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc,
               instr_done, illegal_op
    );

    modport slave (
        output OpCode, Zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemToRead, MemToWrite,
               MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSrc,
               instr_done, illegal_op
    );

endinterface

// File: rtl/uc_decod_estado.sv
// Purely combinational state decoder: maps the current FSM state (plus the
// memory handshake and, in DECODE, the opcode) onto the datapath control word.
module uc_decod_estado
    import uc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] op_code,
    output ctrl_t      ctrl
);

    // Everything defaults to 0 so IDLE and unused encodings drive a quiet datapath.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_supported(op_code);
                ctrl.instr_done = !is_supported(op_code);
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS32 control FSM (R-type, LW, SW, BEQ, J). Holds the state
// register and next-state logic; control outputs come from uc_decod_estado.
module uc_multiciclo
    import uc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    uc_multiciclo_if.master bus
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    // State register; reset wins over any pending memory access.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Instruction sequencing, memory states hold until mem_ready.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:     next_state = ST_FETCH;
            ST_FETCH:    next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.OpCode)
                    OP_RTYPE:     next_state = ST_R_EXEC;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_R_EXEC:   next_state = ST_R_WB;
            ST_R_WB:     next_state = ST_FETCH;
            ST_MEM_ADDR: next_state = (bus.OpCode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   next_state = bus.mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   next_state = ST_FETCH;
            ST_MEM_WR:   next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH:   next_state = ST_FETCH;
            ST_JUMP:     next_state = ST_FETCH;
            default:     next_state = ST_IDLE;
        endcase
    end

    uc_decod_estado u_decod (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .op_code   (bus.OpCode),
        .ctrl      (ctrl)
    );

    // Drive the control word onto the bus.
    always_comb begin
        bus.PCWrite     = ctrl.pc_write;
        bus.PCWriteCond = ctrl.pc_write_cond;
        bus.IorD        = ctrl.i_or_d;
        bus.IRWrite     = ctrl.ir_write;
        bus.MemToRead   = ctrl.mem_read;
        bus.MemToWrite  = ctrl.mem_write;
        bus.MemToReg    = ctrl.mem_to_reg;
        bus.RegDst      = ctrl.reg_dst;
        bus.RegWrite    = ctrl.reg_write;
        bus.AluSrcA     = ctrl.alu_src_a;
        bus.AluSrcB     = ctrl.alu_src_b;
        bus.AluOp       = ctrl.alu_op;
        bus.PCSrc       = ctrl.pc_src;
        bus.instr_done  = ctrl.instr_done;
        bus.illegal_op  = ctrl.illegal_op;
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: the driver pushes the expected control
// word for each cycle, a negedge monitor pops and compares it.
module tb_uc_multiciclo;

    // Expected control word layout:
    // {PCWrite,PCWriteCond,IorD,IRWrite,MemToRead,MemToWrite,MemToReg,RegDst,
    //  RegWrite,AluSrcA,AluSrcB[1:0],AluOp[2:0],PCSrc[1:0],instr_done,illegal_op}
    localparam logic [18:0] E_IDLE    = 19'b0_0_0_0_0_0_0_0_0_0_00_000_00_0_0;
    localparam logic [18:0] E_FETCH_W = 19'b0_0_0_0_1_0_0_0_0_0_01_000_00_0_0;
    localparam logic [18:0] E_FETCH_R = 19'b1_0_0_1_1_0_0_0_0_0_01_000_00_0_0;
    localparam logic [18:0] E_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_11_000_00_0_0;
    localparam logic [18:0] E_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_11_000_00_1_1;
    localparam logic [18:0] E_R_EXEC  = 19'b0_0_0_0_0_0_0_0_0_1_00_010_00_0_0;
    localparam logic [18:0] E_R_WB    = 19'b0_0_0_0_0_0_0_1_1_0_00_000_00_1_0;
    localparam logic [18:0] E_MADDR   = 19'b0_0_0_0_0_0_0_0_0_1_10_000_00_0_0;
    localparam logic [18:0] E_MEM_RD  = 19'b0_0_1_0_1_0_0_0_0_0_00_000_00_0_0;
    localparam logic [18:0] E_MEM_WB  = 19'b0_0_0_0_0_0_1_0_1_0_00_000_00_1_0;
    localparam logic [18:0] E_MWR_W   = 19'b0_0_1_0_0_1_0_0_0_0_00_000_00_0_0;
    localparam logic [18:0] E_MWR_R   = 19'b0_0_1_0_0_1_0_0_0_0_00_000_00_1_0;
    localparam logic [18:0] E_BRANCH  = 19'b0_1_0_0_0_0_0_0_0_1_00_001_01_1_0;
    localparam logic [18:0] E_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_000_10_1_0;

    typedef struct {
        logic [18:0] cw;
        string       tag;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    exp_t exp_q[$];
    exp_t mon_e;
    int   assert_count = 0;
    int   fail_count   = 0;

    always #5 clk = ~clk;

    uc_multiciclo_if bus ();

    uc_multiciclo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Drive one cycle of inputs just after the edge and record what the DUT
    // must present during that cycle.
    task automatic applyStimulus(input logic rst, input logic [5:0] op,
                                 input logic zero, input logic mr,
                                 input logic [18:0] exp_cw, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.OpCode    = op;
        bus.Zero      = zero;
        bus.mem_ready = mr;
        e.cw  = exp_cw;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [18:0] act;
        act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.IRWrite,
               bus.MemToRead, bus.MemToWrite, bus.MemToReg, bus.RegDst,
               bus.RegWrite, bus.AluSrcA, bus.AluSrcB, bus.AluOp, bus.PCSrc,
               bus.instr_done, bus.illegal_op};
        assert_count++;
        if (act !== e.cw) begin
            fail_count++;
            $display("[TB] FAIL %s: got %b expected %b", e.tag, act, e.cw);
        end
        assert_count++;
        if (bus.MemToRead === 1'b1 && bus.MemToWrite === 1'b1) begin
            fail_count++;
            $display("[TB] FAIL %s_rd_wr_excl: got MemToRead=1 MemToWrite=1 expected not both", e.tag);
        end
    endtask

    // Monitor: compare whatever the driver has queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        bus.OpCode    = 6'b000000;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset for three cycles, release, IDLE then FETCH.
        applyStimulus(1, 6'b000000, 0, 0, E_IDLE,    "rst_c1");
        applyStimulus(1, 6'b000000, 0, 0, E_IDLE,    "rst_c2");
        applyStimulus(1, 6'b000000, 0, 0, E_IDLE,    "rst_c3");
        applyStimulus(0, 6'b000000, 0, 1, E_IDLE,    "idle_after_rst");

        // R-type, memory always ready.
        applyStimulus(0, 6'b000000, 0, 1, E_FETCH_R, "r_fetch");
        applyStimulus(0, 6'b000000, 0, 1, E_DECODE,  "r_decode");
        applyStimulus(0, 6'b000000, 0, 1, E_R_EXEC,  "r_exec");
        applyStimulus(0, 6'b000000, 0, 1, E_R_WB,    "r_wb");

        // LW with two wait cycles in MEM_RD: 7 cycles total.
        applyStimulus(0, 6'b100011, 0, 1, E_FETCH_R, "lw_fetch");
        applyStimulus(0, 6'b100011, 0, 1, E_DECODE,  "lw_decode");
        applyStimulus(0, 6'b100011, 0, 1, E_MADDR,   "lw_addr");
        applyStimulus(0, 6'b100011, 0, 0, E_MEM_RD,  "lw_rd_wait1");
        applyStimulus(0, 6'b100011, 0, 0, E_MEM_RD,  "lw_rd_wait2");
        applyStimulus(0, 6'b100011, 0, 1, E_MEM_RD,  "lw_rd_done");
        applyStimulus(0, 6'b100011, 0, 1, E_MEM_WB,  "lw_wb");

        // SW preceded by one fetch wait cycle.
        applyStimulus(0, 6'b101011, 0, 0, E_FETCH_W, "sw_fetch_wait");
        applyStimulus(0, 6'b101011, 0, 1, E_FETCH_R, "sw_fetch");
        applyStimulus(0, 6'b101011, 0, 1, E_DECODE,  "sw_decode");
        applyStimulus(0, 6'b101011, 0, 1, E_MADDR,   "sw_addr");
        applyStimulus(0, 6'b101011, 0, 1, E_MWR_R,   "sw_wr");

        // BEQ taken and not taken, then J.
        applyStimulus(0, 6'b000100, 1, 1, E_FETCH_R, "beq1_fetch");
        applyStimulus(0, 6'b000100, 1, 1, E_DECODE,  "beq1_decode");
        applyStimulus(0, 6'b000100, 1, 1, E_BRANCH,  "beq1_branch");
        applyStimulus(0, 6'b000100, 0, 1, E_FETCH_R, "beq0_fetch");
        applyStimulus(0, 6'b000100, 0, 1, E_DECODE,  "beq0_decode");
        applyStimulus(0, 6'b000100, 0, 1, E_BRANCH,  "beq0_branch");
        applyStimulus(0, 6'b000010, 0, 1, E_FETCH_R, "j_fetch");
        applyStimulus(0, 6'b000010, 0, 1, E_DECODE,  "j_decode");
        applyStimulus(0, 6'b000010, 0, 1, E_JUMP,    "j_jump");

        // Unsupported opcodes: two-cycle instructions.
        applyStimulus(0, 6'b111111, 0, 1, E_FETCH_R, "ill_fetch");
        applyStimulus(0, 6'b111111, 0, 1, E_DEC_ILL, "ill_decode");
        applyStimulus(0, 6'b001000, 0, 1, E_FETCH_R, "ill2_fetch");
        applyStimulus(0, 6'b001000, 0, 1, E_DEC_ILL, "ill2_decode");

        // SW stalled in MEM_WR, then reset aborts it.
        applyStimulus(0, 6'b101011, 0, 1, E_FETCH_R, "abort_fetch");
        applyStimulus(0, 6'b101011, 0, 1, E_DECODE,  "abort_decode");
        applyStimulus(0, 6'b101011, 0, 1, E_MADDR,   "abort_addr");
        applyStimulus(0, 6'b101011, 0, 0, E_MWR_W,   "abort_wr_wait");
        applyStimulus(1, 6'b101011, 0, 0, E_MWR_W,   "abort_wr_rst");
        applyStimulus(0, 6'b101011, 0, 0, E_IDLE,    "abort_idle");
        applyStimulus(0, 6'b000000, 0, 0, E_FETCH_W, "abort_refetch");

        repeat (2) @(posedge clk);
        assert_count++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
